// File: rtl/parametric_fifo_queue_pkg.sv
// Shared sizing constants for the parametric FIFO queue.
// Threshold defaults live here so every instance derives them the same way.
package parametric_fifo_queue_pkg;

    localparam int BYTE_LEN_IN_BITS               = 8;
    localparam int DEFAULT_ENTRY_BYTES            = 8;
    localparam int DEFAULT_QUEUE_SIZE             = 16;
    localparam int DEFAULT_ALMOST_FULL_MARGIN     = 2;
    localparam int DEFAULT_ALMOST_EMPTY_THRESHOLD = 1;

endpackage

// File: rtl/parametric_fifo_queue_ptr_counter.sv
// Wrapping pointer for the FIFO storage array.
// Wrap from the last entry back to 0 is natural binary overflow.
module fifo_ptr_counter #(
    parameter int PTR_WIDTH_IN_BITS = 4
) (
    input  logic                         clk_in,
    input  logic                         reset_n_in,
    input  logic                         clear_in,
    input  logic                         increment_in,
    output logic [PTR_WIDTH_IN_BITS-1:0] ptr_out
);

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            ptr_out <= '0;
        end else if (clear_in) begin
            ptr_out <= '0;
        end else if (increment_in) begin
            ptr_out <= ptr_out + 1'b1;
        end
    end

endmodule

// File: rtl/parametric_fifo_queue.sv
// Flop-based FIFO queue with occupancy-derived status flags and sticky
// overflow/underflow indicators.
module parametric_fifo_queue
    import parametric_fifo_queue_pkg::*;
#(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_BYTES * BYTE_LEN_IN_BITS,
    parameter int QUEUE_SIZE                 = DEFAULT_QUEUE_SIZE,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = $clog2(QUEUE_SIZE),
    parameter int ALMOST_FULL_THRESHOLD      = QUEUE_SIZE - DEFAULT_ALMOST_FULL_MARGIN,
    parameter int ALMOST_EMPTY_THRESHOLD     = DEFAULT_ALMOST_EMPTY_THRESHOLD
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n_in,
    input  logic                                  flush_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                  request_valid_in,
    output logic                                  issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
    output logic                                  request_valid_out,
    input  logic                                  issue_ack_in,
    output logic [QUEUE_PTR_WIDTH_IN_BITS:0]      occupancy_out,
    output logic                                  is_full_out,
    output logic                                  is_empty_out,
    output logic                                  almost_full_out,
    output logic                                  almost_empty_out,
    output logic                                  overflow_out,
    output logic                                  underflow_out
);

    localparam int OCC_W = QUEUE_PTR_WIDTH_IN_BITS + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT   = OCC_W'(QUEUE_SIZE);
    localparam logic [OCC_W-1:0] AF_THRESHOLD = OCC_W'(ALMOST_FULL_THRESHOLD);
    localparam logic [OCC_W-1:0] AE_THRESHOLD = OCC_W'(ALMOST_EMPTY_THRESHOLD);

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] storage [QUEUE_SIZE];
    logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    write_ptr;
    logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    read_ptr;
    logic [OCC_W-1:0]                      occupancy;
    logic                                  accept;
    logic                                  pop;

    // Full-and-pop still refuses the write so the ack never depends on issue_ack_in.
    assign accept = reset_n_in & request_valid_in & ~is_full_out & ~flush_in;
    assign pop    = request_valid_out & issue_ack_in & ~flush_in;

    assign issue_ack_out = accept;

    fifo_ptr_counter #(
        .PTR_WIDTH_IN_BITS (QUEUE_PTR_WIDTH_IN_BITS)
    ) u_write_ptr (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .clear_in     (flush_in),
        .increment_in (accept),
        .ptr_out      (write_ptr)
    );

    fifo_ptr_counter #(
        .PTR_WIDTH_IN_BITS (QUEUE_PTR_WIDTH_IN_BITS)
    ) u_read_ptr (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .clear_in     (flush_in),
        .increment_in (pop),
        .ptr_out      (read_ptr)
    );

    // Storage is left uncleared on reset/flush; the output mask hides stale data.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            storage[write_ptr] <= request_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            occupancy <= '0;
        end else if (flush_in) begin
            occupancy <= '0;
        end else if (accept && !pop) begin
            occupancy <= occupancy + 1'b1;
        end else if (pop && !accept) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            if (request_valid_in && is_full_out) begin
                overflow_out <= 1'b1;
            end
            if (issue_ack_in && is_empty_out) begin
                underflow_out <= 1'b1;
            end
        end
    end

    assign occupancy_out     = occupancy;
    assign is_full_out       = (occupancy == FULL_COUNT);
    assign is_empty_out      = (occupancy == '0);
    assign almost_full_out   = (occupancy >= AF_THRESHOLD);
    assign almost_empty_out  = (occupancy <= AE_THRESHOLD);
    assign request_valid_out = ~is_empty_out;
    assign request_out       = request_valid_out ? storage[read_ptr] : '0;

endmodule

// File: tb/tb_parametric_fifo_queue.sv
// Bench for parametric_fifo_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_parametric_fifo_queue;

    localparam int W  = 64;
    localparam int QS = 16;
    localparam int PW = 4;

    logic          clk_in = 1'b0;
    logic          reset_n_in;
    logic          flush_in;
    logic [W-1:0]  request_in;
    logic          request_valid_in;
    logic          issue_ack_out;
    logic [W-1:0]  request_out;
    logic          request_valid_out;
    logic          issue_ack_in;
    logic [PW:0]   occupancy_out;
    logic          is_full_out;
    logic          is_empty_out;
    logic          almost_full_out;
    logic          almost_empty_out;
    logic          overflow_out;
    logic          underflow_out;

    parametric_fifo_queue dut (
        .clk_in            (clk_in),
        .reset_n_in        (reset_n_in),
        .flush_in          (flush_in),
        .request_in        (request_in),
        .request_valid_in  (request_valid_in),
        .issue_ack_out     (issue_ack_out),
        .request_out       (request_out),
        .request_valid_out (request_valid_out),
        .issue_ack_in      (issue_ack_in),
        .occupancy_out     (occupancy_out),
        .is_full_out       (is_full_out),
        .is_empty_out      (is_empty_out),
        .almost_full_out   (almost_full_out),
        .almost_empty_out  (almost_empty_out),
        .overflow_out      (overflow_out),
        .underflow_out     (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue semantics evaluated on the rising edge.
    always @(posedge clk_in) begin
        int  n;
        bit  full, empty, acc, pp;
        n     = mq.size();
        full  = (n == QS);
        empty = (n == 0);
        acc   = reset_n_in && request_valid_in && !full && !flush_in;
        pp    = !empty && issue_ack_in && !flush_in;
        if (!reset_n_in) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (request_valid_in && full) m_ovf = 1'b1;
            if (issue_ack_in && empty)    m_udf = 1'b1;
            if (flush_in) begin
                mq.delete();
            end else begin
                if (pp)  void'(mq.pop_front());
                if (acc) mq.push_back(request_in);
            end
        end
    end

    always @(negedge clk_in) begin
        int n;
        if (check_en) begin
            n = mq.size();
            check("occupancy",    W'(occupancy_out),     W'(n));
            check("is_full",      W'(is_full_out),       W'(n == QS));
            check("is_empty",     W'(is_empty_out),      W'(n == 0));
            check("almost_full",  W'(almost_full_out),   W'(n >= QS - 2));
            check("almost_empty", W'(almost_empty_out),  W'(n <= 1));
            check("valid_out",    W'(request_valid_out), W'(n != 0));
            check("request_out",  request_out,           (n == 0) ? '0 : mq[0]);
            check("issue_ack",    W'(issue_ack_out),
                  W'(reset_n_in && request_valid_in && (n != QS) && !flush_in));
            check("overflow",     W'(overflow_out),      W'(m_ovf));
            check("underflow",    W'(underflow_out),     W'(m_udf));
        end
    end

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [W-1:0] d, input logic a);
        reset_n_in       = r;
        flush_in         = f;
        request_valid_in = v;
        request_in       = d;
        issue_ack_in     = a;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check_en = 1'b1;
        tick();
        check("rst_occupancy",    W'(occupancy_out),    W'(0));
        check("rst_empty",        W'(is_empty_out),     W'(1));
        check("rst_almost_empty", W'(almost_empty_out), W'(1));
        check("rst_request_out",  request_out,          W'(0));
        check("rst_ack_forced",   W'(issue_ack_out),    W'(0));

        // Four back-to-back pushes, no consumer
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hA1 + i), 1'b0);
            #1;
            check("push_ack", W'(issue_ack_out), W'(1));
            tick();
            if (i == 0) check("first_head", request_out, W'(8'hA1));
        end
        check("occ_after_4", W'(occupancy_out), W'(4));
        check("model_size_4", W'(mq.size()), W'(4));

        for (int i = 4; i < QS; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hA1 + i), 1'b0);
            tick();
        end
        check("full_flag", W'(is_full_out), W'(1));
        drive(1'b1, 1'b0, 1'b1, W'(64'hDEAD), 1'b1);
        #1;
        check("full_no_ack", W'(issue_ack_out), W'(0));
        tick();
        check("overflow_set",  W'(overflow_out),  W'(1));
        check("occ_after_ovf", W'(occupancy_out), W'(15));
        check("head_after_ovf", request_out, W'(8'hA2));
        for (int i = 0; i < QS - 1; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        check("drained", W'(is_empty_out), W'(1));

        // Push and pop together at occupancy 1
        drive(1'b1, 1'b0, 1'b1, W'(8'hB1), 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, W'(8'hB2), 1'b1);
        tick();
        check("pp_occ",   W'(occupancy_out),     W'(1));
        check("pp_head",  request_out,           W'(8'hB2));
        check("pp_valid", W'(request_valid_out), W'(1));

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(i), 1'b0);
            tick();
        end
        check("occ_10", W'(occupancy_out), W'(10));
        drive(1'b1, 1'b1, 1'b1, W'(64'hF00D), 1'b1);
        #1;
        check("flush_no_ack", W'(issue_ack_out), W'(0));
        tick();
        check("flush_occ",   W'(occupancy_out), W'(0));
        check("flush_empty", W'(is_empty_out),  W'(1));
        check("flush_ovf",   W'(overflow_out),  W'(1));
        check("flush_udf",   W'(underflow_out), W'(0));

        // Sticky underflow survives flush, cleared by reset
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check("udf_set", W'(underflow_out), W'(1));
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("udf_held_flush", W'(underflow_out), W'(1));
        drive(1'b0, 1'b0, 1'b1, W'(1), 1'b0);
        #1;
        check("ack_in_reset", W'(issue_ack_out), W'(0));
        tick();
        check("udf_cleared", W'(underflow_out), W'(0));
        check("ovf_cleared", W'(overflow_out),  W'(0));

        // Offset pointers, then full sweep crossing the wrap point
        for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b1, W'(i), 1'b0); tick(); end
        for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0, '0, 1'b1); tick(); end
        for (int k = 1; k <= QS; k++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hC0 + k), 1'b0);
            tick();
            check("sweep_up_af", W'(almost_full_out),  W'(k >= 14));
            check("sweep_up_ae", W'(almost_empty_out), W'(k <= 1));
        end
        for (int k = 1; k <= QS; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            #1;
            check("sweep_order", request_out, W'(8'hC0 + k));
            tick();
            check("sweep_dn_af", W'(almost_full_out),  W'((QS - k) >= 14));
            check("sweep_dn_ae", W'(almost_empty_out), W'((QS - k) <= 1));
        end

        // Randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 3000; c++) begin
            int  bias;
            logic r, f, v, a;
            bias = ((c / 150) % 2 == 0) ? 75 : 30;
            r = ($urandom_range(0, 299) != 0);
            f = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 99) < bias);
            a = ($urandom_range(0, 99) < (100 - bias));
            drive(r, f, v, {$urandom, $urandom}, a);
            tick();
        end

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
